// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, default opcodes and IDCODE.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'h0,
        RTI    = 4'h1,
        SEL_DR = 4'h2,
        CAP_DR = 4'h3,
        SH_DR  = 4'h4,
        EX1_DR = 4'h5,
        PAU_DR = 4'h6,
        EX2_DR = 4'h7,
        UPD_DR = 4'h8,
        SEL_IR = 4'h9,
        CAP_IR = 4'hA,
        SH_IR  = 4'hB,
        EX1_IR = 4'hC,
        PAU_IR = 4'hD,
        EX2_IR = 4'hE,
        UPD_IR = 4'hF
    } tap_state_t;

    // Opcodes are held 8 bits wide (the IR_WIDTH maximum) and truncated
    // or zero-extended to the configured IR width where used.
    localparam logic [7:0]  JTAG_IR_IDCODE    = 8'h0E;
    localparam logic [7:0]  JTAG_IR_USER      = 8'h0A;
    localparam logic [7:0]  JTAG_IR_BYPASS    = 8'hFF;
    localparam logic [31:0] JTAG_IDCODE_VALUE = 32'h000F_AF01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine.
// Ports:
//   tck, trst_n  - TAP clock, asynchronous active-low reset
//   tms          - mode select, sampled on rising tck
//   enable       - when low the state holds and all strobes are 0
//   state        - current TAP state
//   capture_ir/shift_ir/update_ir, capture_dr/shift_dr/update_dr
//                - decoded strobes: high while in the matching state, so
//                  the action happens on the rising edge that ends it
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    input  logic       enable,
    output tap_state_t state,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q <= TLR;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms ? SEL_DR : RTI;
            SEL_IR: state_d = tms ? TLR    : CAP_IR;
            CAP_IR: state_d = tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_comb begin
        state      = state_q;
        capture_ir = enable && (state_q == CAP_IR);
        shift_ir   = enable && (state_q == SH_IR);
        update_ir  = enable && (state_q == UPD_IR);
        capture_dr = enable && (state_q == CAP_DR);
        shift_dr   = enable && (state_q == SH_DR);
        update_dr  = enable && (state_q == UPD_DR);
    end

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP: TAP FSM, instruction register and BYPASS / IDCODE / USER data
// registers, with tdo driven from negative-edge flops.
// Ports:
//   tck, trst_n      - TAP clock, asynchronous active-low reset
//   tms, tdi         - sampled on rising tck
//   enable           - low: every register holds, user_dr_update is 0
//   tdo, tdo_oe      - serial out and its enable, updated on falling tck
//   tap_state        - current FSM state (debug)
//   ir_value         - active instruction
//   user_dr_capture  - value captured into the USER DR in Capture-DR
//   user_dr_out      - last value written by Update-DR with USER selected
//   user_dr_update   - one-tck pulse when user_dr_out is written
module jtag_tap
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH      = 4,
    parameter logic [31:0] IDCODE_VALUE  = JTAG_IDCODE_VALUE,
    parameter logic [7:0]  IR_IDCODE     = JTAG_IR_IDCODE,
    parameter logic [7:0]  IR_USER       = JTAG_IR_USER,
    parameter int unsigned USER_DR_WIDTH = 8
) (
    input  logic                     tck,
    input  logic                     trst_n,
    input  logic                     tms,
    input  logic                     tdi,
    input  logic                     enable,
    output logic                     tdo,
    output logic                     tdo_oe,
    output logic [3:0]               tap_state,
    output logic [IR_WIDTH-1:0]      ir_value,
    input  logic [USER_DR_WIDTH-1:0] user_dr_capture,
    output logic [USER_DR_WIDTH-1:0] user_dr_out,
    output logic                     user_dr_update
);

    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(IR_IDCODE);
    localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(IR_USER);
    localparam logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(JTAG_IR_BYPASS);

    tap_state_t state;
    logic capture_ir, shift_ir, update_ir;
    logic capture_dr, shift_dr, update_dr;

    logic [IR_WIDTH-1:0]      ir_shift;
    logic [31:0]              idcode_sr;
    logic [USER_DR_WIDTH-1:0] user_sr;
    logic                     bypass_sr;
    logic                     sel_idcode;
    logic                     sel_user;
    logic                     dr_lsb;

    jtag_tap_fsm u_fsm (
        .tck        (tck),
        .trst_n     (trst_n),
        .tms        (tms),
        .enable     (enable),
        .state      (state),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr)
    );

    assign tap_state = state;

    // Instruction register: shift stage plus active instruction.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_shift <= '0;
            ir_value <= OP_IDCODE;
        end else if (enable) begin
            if (capture_ir) begin
                ir_shift <= IR_WIDTH'(1);
            end else if (shift_ir) begin
                ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
            end
            if (update_ir) begin
                ir_value <= ir_shift;
            end else if (state == TLR) begin
                ir_value <= OP_IDCODE;
            end
        end
    end

    // All-ones always means BYPASS, even if an opcode parameter collides.
    always_comb begin
        sel_idcode = (ir_value == OP_IDCODE) && (ir_value != OP_BYPASS);
        sel_user   = (ir_value == OP_USER) && !sel_idcode && (ir_value != OP_BYPASS);
    end

    // Data registers. Only the selected DR captures or shifts.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            idcode_sr <= '0;
            user_sr   <= '0;
            bypass_sr <= 1'b0;
        end else if (enable) begin
            if (capture_dr) begin
                if (sel_idcode) begin
                    idcode_sr <= IDCODE_VALUE;
                end else if (sel_user) begin
                    user_sr <= user_dr_capture;
                end else begin
                    bypass_sr <= 1'b0;
                end
            end else if (shift_dr) begin
                if (sel_idcode) begin
                    idcode_sr <= {tdi, idcode_sr[31:1]};
                end else if (sel_user) begin
                    // Written as shift/OR so a 1-bit USER DR needs no special case.
                    user_sr <= (user_sr >> 1)
                             | (USER_DR_WIDTH'(tdi) << (USER_DR_WIDTH - 1));
                end else begin
                    bypass_sr <= tdi;
                end
            end
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            user_dr_out    <= '0;
            user_dr_update <= 1'b0;
        end else begin
            // update_dr is already gated by enable, so a stall clears the pulse.
            user_dr_update <= update_dr && sel_user;
            if (update_dr && sel_user) begin
                user_dr_out <= user_sr;
            end
        end
    end

    always_comb begin
        dr_lsb = bypass_sr;
        if (sel_idcode) begin
            dr_lsb = idcode_sr[0];
        end else if (sel_user) begin
            dr_lsb = user_sr[0];
        end
    end

    // Falling-edge output stage so the host sees stable data at the next rise.
    always_ff @(negedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tdo    <= 1'b0;
            tdo_oe <= 1'b0;
        end else if (enable) begin
            if (state == SH_IR) begin
                tdo    <= ir_shift[0];
                tdo_oe <= 1'b1;
            end else if (state == SH_DR) begin
                tdo    <= dr_lsb;
                tdo_oe <= 1'b1;
            end else begin
                tdo    <= 1'b0;
                tdo_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap.sv
// Self-checking bench for jtag_tap. Expected scan output is modelled as the
// serial stream "captured value followed by the bits shifted in".
module tb_jtag_tap;

    localparam logic [31:0] IDCODE = 32'h000F_AF01;
    localparam logic [3:0]  OP_ID  = 4'hE;
    localparam logic [3:0]  OP_USR = 4'hA;

    logic       tck = 1'b0;
    logic       trst_n = 1'b0;
    logic       tms = 1'b0;
    logic       tdi = 1'b0;
    logic       enable = 1'b1;
    logic       tdo;
    logic       tdo_oe;
    logic [3:0] tap_state;
    logic [3:0] ir_value;
    logic [7:0] user_dr_capture = 8'h00;
    logic [7:0] user_dr_out;
    logic       user_dr_update;

    int tests = 0;
    int failed = 0;
    int upd_cnt = 0;
    logic [7:0] last_upd = 8'h00;
    logic [7:0] exp_user_out = 8'h00;

    jtag_tap #(
        .IR_WIDTH      (4),
        .IDCODE_VALUE  (32'h000F_AF01),
        .IR_IDCODE     (8'h0E),
        .IR_USER       (8'h0A),
        .USER_DR_WIDTH (8)
    ) dut (
        .tck             (tck),
        .trst_n          (trst_n),
        .tms             (tms),
        .tdi             (tdi),
        .enable          (enable),
        .tdo             (tdo),
        .tdo_oe          (tdo_oe),
        .tap_state       (tap_state),
        .ir_value        (ir_value),
        .user_dr_capture (user_dr_capture),
        .user_dr_out     (user_dr_out),
        .user_dr_update  (user_dr_update)
    );

    always @(negedge tck) begin
        if (user_dr_update === 1'b1) begin
            upd_cnt++;
            last_upd = user_dr_out;
        end
    end

    task automatic tick();
        #4 tck = 1'b1;
        #5 tck = 1'b0;
        #1;
    endtask

    task automatic clk(input logic t, input logic d);
        tms = t;
        tdi = d;
        tick();
    endtask

    task automatic reset_dut();
        trst_n = 1'b0;
        #2 trst_n = 1'b1;
        #1;
        clk(1'b0, 1'b0);
    endtask

    // From RTI: full DR scan of n bits, ending back in RTI.
    task automatic scan_dr(input int n, input logic [63:0] din,
                           output logic [63:0] dout, output logic oe_ok);
        dout = '0;
        oe_ok = 1'b1;
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            if (tdo_oe !== 1'b1) oe_ok = 1'b0;
            clk(i == n - 1, din[i]);
        end
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    // From RTI: full IR scan, ending back in RTI.
    task automatic scan_ir(input logic [3:0] din, output logic [3:0] dout,
                           output logic oe_ok);
        dout = '0;
        oe_ok = 1'b1;
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dout[i] = tdo;
            if (tdo_oe !== 1'b1) oe_ok = 1'b0;
            clk(i == 3, din[i]);
        end
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        trst_n = 1'b0;
        #3 trst_n = 1'b1;
        #1;
        clk(1'b0, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        tests++;
        if (tdo_oe !== 1'b1) begin
            failed++;
            $display("FAIL pre_reset_oe: tdo_oe=%b expected 1", tdo_oe);
        end
        trst_n = 1'b0;
        #1;
        tests++;
        if (tap_state !== 4'h0) begin
            failed++;
            $display("FAIL reset_state: tap_state=%0h expected 0", tap_state);
        end
        tests++;
        if (ir_value !== OP_ID) begin
            failed++;
            $display("FAIL reset_ir: ir_value=%0h expected %0h", ir_value, OP_ID);
        end
        tests++;
        if (tdo !== 1'b0 || tdo_oe !== 1'b0) begin
            failed++;
            $display("FAIL reset_tdo: tdo=%b tdo_oe=%b expected 0 0", tdo, tdo_oe);
        end
        tests++;
        if (user_dr_out !== 8'h00 || user_dr_update !== 1'b0) begin
            failed++;
            $display("FAIL reset_user: out=%0h upd=%b expected 0 0", user_dr_out, user_dr_update);
        end
        #2 trst_n = 1'b1;
        #1;
        clk(1'b0, 1'b0);
        tests++;
        if (tap_state !== 4'h1) begin
            failed++;
            $display("FAIL tlr_to_rti: tap_state=%0h expected 1", tap_state);
        end
    endtask

    task automatic test_forced_tlr();
        logic [3:0] path [5] = '{4'h5, 4'h8, 4'h2, 4'h9, 4'h0};
        int base;
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        base = upd_cnt;
        for (int k = 0; k < 5; k++) begin
            clk(1'b1, 1'($urandom));
            tests++;
            if (tap_state !== path[k]) begin
                failed++;
                $display("FAIL forced_tlr_step%0d: tap_state=%0h expected %0h", k, tap_state, path[k]);
            end
        end
        tests++;
        if (upd_cnt !== base) begin
            failed++;
            $display("FAIL forced_tlr_noupd: pulses=%0d expected %0d", upd_cnt, base);
        end
        clk(1'b0, 1'b0);
    endtask

    task automatic test_idcode();
        logic [63:0] dout;
        logic oe_ok;
        reset_dut();
        scan_dr(32, {$urandom, $urandom}, dout, oe_ok);
        tests++;
        if (dout[0] !== 1'b1) begin
            failed++;
            $display("FAIL idcode_first_bit: got %b expected 1", dout[0]);
        end
        tests++;
        if (dout[31:0] !== IDCODE || !oe_ok) begin
            failed++;
            $display("FAIL idcode_read: got %08h oe_ok=%b expected %08h oe_ok=1", dout[31:0], oe_ok, IDCODE);
        end
    endtask

    task automatic test_tlr_reload();
        logic [3:0] d;
        logic ok;
        scan_ir(OP_USR, d, ok);
        tests++;
        if (ir_value !== OP_USR) begin
            failed++;
            $display("FAIL ir_load_user: ir_value=%0h expected %0h", ir_value, OP_USR);
        end
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        tests++;
        if (tap_state !== 4'h0 || ir_value !== OP_USR) begin
            failed++;
            $display("FAIL tlr_entry: state=%0h ir=%0h expected 0 %0h", tap_state, ir_value, OP_USR);
        end
        clk(1'b1, 1'b0);
        tests++;
        if (ir_value !== OP_ID) begin
            failed++;
            $display("FAIL tlr_reload: ir_value=%0h expected %0h", ir_value, OP_ID);
        end
        clk(1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        logic [3:0] d;
        logic ok;
        logic [63:0] din;
        logic [63:0] dout;
        logic [63:0] expv;
        scan_ir(4'hF, d, ok);
        tests++;
        if (d !== 4'b0001 || !ok) begin
            failed++;
            $display("FAIL ir_capture: tdo bits=%b oe_ok=%b expected 0001 1", d, ok);
        end
        tests++;
        if (ir_value !== 4'hF) begin
            failed++;
            $display("FAIL ir_bypass: ir_value=%0h expected f", ir_value);
        end
        din = 64'b0_1101;
        scan_dr(5, din, dout, ok);
        tests++;
        if (dout[4:0] !== 5'b11010 || !ok) begin
            failed++;
            $display("FAIL bypass_fixed: got %b expected 11010", dout[4:0]);
        end
        din = {$urandom, $urandom};
        scan_dr(40, din, dout, ok);
        expv = (din << 1) & 64'hFF_FFFF_FFFF;
        tests++;
        if (dout !== expv || !ok) begin
            failed++;
            $display("FAIL bypass_random: got %0h expected %0h", dout, expv);
        end
    endtask

    task automatic test_user();
        logic [3:0] d;
        logic ok;
        logic [63:0] dout;
        int base;
        user_dr_capture = 8'hA5;
        scan_ir(OP_USR, d, ok);
        tests++;
        if (ir_value !== OP_USR) begin
            failed++;
            $display("FAIL user_ir: ir_value=%0h expected %0h", ir_value, OP_USR);
        end
        base = upd_cnt;
        scan_dr(8, 64'h3C, dout, ok);
        exp_user_out = 8'h3C;
        tests++;
        if (dout[7:0] !== 8'hA5 || !ok) begin
            failed++;
            $display("FAIL user_capture: got %0h expected a5", dout[7:0]);
        end
        tests++;
        if (upd_cnt !== base + 1 || last_upd !== 8'h3C) begin
            failed++;
            $display("FAIL user_update_pulse: pulses=%0d val=%0h expected %0d 3c", upd_cnt - base, last_upd, 1);
        end
        tests++;
        if (user_dr_out !== exp_user_out) begin
            failed++;
            $display("FAIL user_out: got %0h expected %0h", user_dr_out, exp_user_out);
        end
    endtask

    task automatic test_random_scans();
        logic [3:0] op;
        logic [3:0] d;
        logic ok;
        logic [63:0] din;
        logic [63:0] dout;
        logic [7:0] cap;
        logic [127:0] s;
        logic [127:0] expv;
        int n;
        int w;
        int base;
        for (int k = 0; k < 9; k++) begin
            op = (k % 3 == 0) ? OP_ID : (k % 3 == 1) ? OP_USR : 4'($urandom_range(0, 15));
            cap = 8'($urandom);
            din = {$urandom, $urandom};
            n = $urandom_range(1, 40);
            user_dr_capture = cap;
            scan_ir(op, d, ok);
            tests++;
            if (d !== 4'b0001 || ir_value !== op) begin
                failed++;
                $display("FAIL rand_ir%0d: cap=%b ir=%0h expected 0001 %0h", k, d, ir_value, op);
            end
            if (op == OP_ID) begin
                s = 128'(IDCODE); w = 32;
            end else if (op == OP_USR) begin
                s = 128'(cap); w = 8;
            end else begin
                s = '0; w = 1;
            end
            s = s | (128'(din) << w);
            expv = s & ((128'd1 << n) - 128'd1);
            base = upd_cnt;
            scan_dr(n, din, dout, ok);
            if (op == OP_USR) exp_user_out = 8'(s >> n);
            tests++;
            if (dout !== expv[63:0] || !ok) begin
                failed++;
                $display("FAIL rand_dr%0d: op=%0h n=%0d got %0h expected %0h", k, op, n, dout, expv[63:0]);
            end
            tests++;
            if (user_dr_out !== exp_user_out || upd_cnt !== base + ((op == OP_USR) ? 1 : 0)) begin
                failed++;
                $display("FAIL rand_upd%0d: out=%0h pulses=%0d expected %0h %0d", k, user_dr_out,
                         upd_cnt - base, exp_user_out, (op == OP_USR) ? 1 : 0);
            end
        end
    endtask

    task automatic test_stall_abort();
        logic [3:0] d;
        logic ok;
        logic [7:0] cap;
        logic [7:0] din;
        logic [7:0] dout;
        int base;
        cap = 8'h5A;
        din = 8'($urandom);
        user_dr_capture = cap;
        scan_ir(OP_USR, d, ok);
        base = upd_cnt;
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                enable = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    clk(1'b1, 1'($urandom));
                    tests++;
                    if (tap_state !== 4'h4 || tdo !== cap[3] || tdo_oe !== 1'b1) begin
                        failed++;
                        $display("FAIL stall%0d: state=%0h tdo=%b oe=%b expected 4 %b 1", k, tap_state, tdo, tdo_oe, cap[3]);
                    end
                end
                enable = 1'b1;
            end
            dout[i] = tdo;
            clk(i == 7, din[i]);
        end
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        tests++;
        if (dout !== cap || user_dr_out !== din || upd_cnt !== base + 1) begin
            failed++;
            $display("FAIL stall_resume: got %0h out=%0h pulses=%0d expected %0h %0h 1", dout, user_dr_out, upd_cnt - base, cap, din);
        end
        base = upd_cnt;
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) clk(1'b0, 1'($urandom));
        trst_n = 1'b0;
        #1;
        tests++;
        if (tdo_oe !== 1'b0 || tap_state !== 4'h0 || ir_value !== OP_ID) begin
            failed++;
            $display("FAIL abort_reset: oe=%b state=%0h ir=%0h expected 0 0 %0h", tdo_oe, tap_state, ir_value, OP_ID);
        end
        #2 trst_n = 1'b1;
        #1;
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        tests++;
        if (upd_cnt !== base || user_dr_out !== 8'h00) begin
            failed++;
            $display("FAIL abort_noupd: pulses=%0d out=%0h expected 0 0", upd_cnt - base, user_dr_out);
        end
    endtask

    initial begin
        test_reset();
        test_forced_tlr();
        test_idcode();
        test_tlr_reload();
        test_bypass();
        test_user();
        test_random_scans();
        test_stall_abort();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
